// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the adder result stage
//
// Purpose: default datapath width, the bit positions of the status flags inside
//          a buffered payload, and the signed saturation limits used when the
//          stage is built with SATURATE_EN.
// Ports:   none (package).
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int CNT_WIDTH_DEFAULT = 16;

    // Flag positions in the low bits of the payload; Result sits above them.
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_BITS = 4;

    // Most positive and most negative two's-complement values.
    localparam logic [ADDER_WIDTH-1:0] SAT_MAX = {1'b0, {(ADDER_WIDTH-1){1'b1}}};
    localparam logic [ADDER_WIDTH-1:0] SAT_MIN = {1'b1, {(ADDER_WIDTH-1){1'b0}}};

endpackage

// File: rtl/result_skid_buffer.sv
// rtl/result_skid_buffer.sv - generic 2-entry valid/ready skid buffer
//
// Purpose: holds up to two payload beats in strict FIFO order. The main slot
//          drives the outputs; the skid slot catches a beat accepted while the
//          main slot is stalled. o_ready is registered.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid, o_ready    upstream handshake
//   i_data  [DATA_W]    upstream payload
//   o_valid, i_ready    downstream handshake
//   o_data  [DATA_W]    downstream payload (main slot)
module result_skid_buffer #(
    parameter int DATA_W = 36
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;

    logic              w_main_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_in_fire;
    logic              w_main_free;

    assign w_in_fire   = i_valid && r_in_ready;
    // Main slot can take a new beat this cycle if empty or being drained.
    assign w_main_free = !r_main_valid || i_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (w_main_free) begin
            if (r_skid_valid) begin
                // Skid moves forward with no bubble. in_ready was low, so
                // w_in_fire is 0 here and the skid slot empties.
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = r_skid_data;
                w_skid_valid_nxt = w_in_fire;
                if (w_in_fire) begin
                    w_skid_data_nxt = i_data;
                end
            end else begin
                w_main_valid_nxt = w_in_fire;
                if (w_in_fire) begin
                    w_main_data_nxt = i_data;
                end
            end
        end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule

// File: rtl/adder_result_stage.sv
// rtl/adder_result_stage.sv - registered result/flag stage behind the carry-bypass adder
//
// Purpose: captures Sum/Cout plus operand signs, derives Z/N/C/V, buffers the
//          result through a 2-entry skid buffer and counts signed overflows
//          with a saturating counter.
// Configuration: define SATURATE_EN to clamp overflowing results to the signed
//          limits; otherwise Result is the wrapped Sum.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input handshake (in_ready registered)
//   a_sign, b_sign       operand MSBs that produced Sum
//   Sum [WIDTH], Cout    adder outputs
//   out_valid, out_ready output handshake
//   Result [WIDTH]       registered result
//   FlagZ/N/C/V          status flags of the Result transaction
//   ovf_clr              synchronous clear of OvfCount
//   OvfCount [CNT_WIDTH] saturating count of accepted beats with V=1
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH     = ADDER_WIDTH,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic [WIDTH-1:0]     Sum,
    input  logic                 Cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     Result,
    output logic                 FlagZ,
    output logic                 FlagN,
    output logic                 FlagC,
    output logic                 FlagV,
    input  logic                 ovf_clr,
    output logic [CNT_WIDTH-1:0] OvfCount
);

    localparam int PAYLOAD_W = WIDTH + FLAG_BITS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 w_in_fire;
    logic                 w_v;
    logic [WIDTH-1:0]     w_result;
    logic [PAYLOAD_W-1:0] w_in_payload;
    logic [PAYLOAD_W-1:0] w_out_payload;
    logic                 w_buf_ready;
    logic [CNT_WIDTH-1:0] r_ovf_count;

    assign w_in_fire = in_valid && w_buf_ready;

    // Overflow: operands share a sign and the sum's sign differs from it.
    assign w_v = (a_sign == b_sign) && (Sum[WIDTH-1] != a_sign);

`ifdef SATURATE_EN
    assign w_result = w_v ? (a_sign ? SAT_MIN : SAT_MAX) : Sum;
`else
    assign w_result = Sum;
`endif

    always_comb begin
        w_in_payload                   = '0;
        w_in_payload[PAYLOAD_W-1:FLAG_BITS] = w_result;
        w_in_payload[FLAG_Z]           = (w_result == '0);
        w_in_payload[FLAG_N]           = w_result[WIDTH-1];
        w_in_payload[FLAG_C]           = Cout;
        w_in_payload[FLAG_V]           = w_v;
    end

    result_skid_buffer #(
        .DATA_W (PAYLOAD_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (w_buf_ready),
        .i_data  (w_in_payload),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_payload)
    );

    // Clear has priority over a same-cycle overflow beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (ovf_clr) begin
            r_ovf_count <= '0;
        end else if (w_in_fire && w_v && (r_ovf_count != CNT_MAX)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign in_ready = w_buf_ready;
    assign Result   = w_out_payload[PAYLOAD_W-1:FLAG_BITS];
    assign FlagZ    = w_out_payload[FLAG_Z];
    assign FlagN    = w_out_payload[FLAG_N];
    assign FlagC    = w_out_payload[FLAG_C];
    assign FlagV    = w_out_payload[FLAG_V];
    assign OvfCount = r_ovf_count;

endmodule

// File: tb/tb_adder_result_stage.sv
// tb/tb_adder_result_stage.sv - directed self-checking bench for adder_result_stage
module tb_adder_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        a_sign;
    logic        b_sign;
    logic [31:0] Sum;
    logic        Cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        FlagZ;
    logic        FlagN;
    logic        FlagC;
    logic        FlagV;
    logic        ovf_clr;
    logic [3:0]  OvfCount;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_result_stage #(
        .WIDTH     (32),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .Sum       (Sum),
        .Cout      (Cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .FlagZ     (FlagZ),
        .FlagN     (FlagN),
        .FlagC     (FlagC),
        .FlagV     (FlagV),
        .ovf_clr   (ovf_clr),
        .OvfCount  (OvfCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic c,
                         input logic as, input logic bs);
        in_valid = v;
        Sum      = s;
        Cout     = c;
        a_sign   = as;
        b_sign   = bs;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {FlagZ, FlagN, FlagC, FlagV};
    endfunction

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", Result, 32'd0);
        chk("rst_flags", flags(), 4'b0000);
        chk("rst_ovf", OvfCount, 4'd0);
        rst = 1'b0;
        tick();

        // 1: 100 + -90 = 10
        drive(1'b1, 32'd10, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_result", Result, 32'd10);
        chk("t1_flags_zncv", flags(), 4'b0010);

        // 2: 0x7FFFFFFF + 1 overflows positive
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
`ifdef SATURATE_EN
        chk("t2_result", Result, 32'h7FFF_FFFF);
        chk("t2_flags_zncv", flags(), 4'b0001);
`else
        chk("t2_result", Result, 32'h8000_0000);
        chk("t2_flags_zncv", flags(), 4'b0101);
`endif
        chk("t2_ovf", OvfCount, 4'd1);

        // 3: 0x80000000 + -1 overflows negative, then 10 + -10 = 0
        drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        tick();
`ifdef SATURATE_EN
        chk("t3_result", Result, 32'h8000_0000);
        chk("t3_flags_zncv", flags(), 4'b0111);
`else
        chk("t3_result", Result, 32'h7FFF_FFFF);
        chk("t3_flags_zncv", flags(), 4'b0011);
`endif
        chk("t3_ovf", OvfCount, 4'd2);
        drive(1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t3z_result", Result, 32'd0);
        chk("t3z_flags_zncv", flags(), 4'b1010);
        tick();
        chk("t3_drained", out_valid, 1'b0);

        // 4: backpressure with 190, -190, -80
        out_ready = 1'b0;
        drive(1'b1, 32'd190, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t4a_valid", out_valid, 1'b1);
        chk("t4a_result", Result, 32'd190);
        chk("t4a_in_ready", in_ready, 1'b1);
        drive(1'b1, 32'hFFFF_FF42, 1'b1, 1'b1, 1'b1);
        tick();
        chk("t4b_result_held", Result, 32'd190);
        chk("t4b_in_ready", in_ready, 1'b0);
        drive(1'b1, 32'hFFFF_FFB0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("t4c_result_held", Result, 32'd190);
        chk("t4c_flags_held", flags(), 4'b0000);
        chk("t4c_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("t4d_valid", out_valid, 1'b1);
        chk("t4d_result", Result, 32'hFFFF_FF42);
        chk("t4d_flags_zncv", flags(), 4'b0110);
        chk("t4d_in_ready", in_ready, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t4e_valid", out_valid, 1'b1);
        chk("t4e_result", Result, 32'hFFFF_FFB0);
        chk("t4e_flags_zncv", flags(), 4'b0100);
        tick();
        chk("t4f_drained", out_valid, 1'b0);

        // 5: saturating counter (4 bits here)
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_clear", OvfCount, 4'd0);
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 14) chk("t5_ovf14", OvfCount, 4'd14);
            if (i == 15) chk("t5_ovf15", OvfCount, 4'd15);
        end
        chk("t5_ovf_sat", OvfCount, 4'd15);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_clr_wins", OvfCount, 4'd0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t5_resume", OvfCount, 4'd1);
        tick();

        // 6: async reset with both slots full
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd6, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t6_full_in_ready", in_ready, 1'b0);
        chk("t6_ovf_pre", OvfCount, 4'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_in_ready", in_ready, 1'b1);
        chk("t6_rst_ovf", OvfCount, 4'd0);
        chk("t6_rst_result", Result, 32'd0);
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 32'd42, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_valid", out_valid, 1'b0);
        tick();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t6_post_valid", out_valid, 1'b1);
        chk("t6_post_result", Result, 32'd42);
        chk("t6_post_flags", flags(), 4'b0000);
        tick();
        chk("t6_post_drained", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
